port_stimulus_sequencer: RTL and testbench



---
 rtl/port_stimulus_sequencer_pkg.sv | 13 +
 rtl/port_stimulus_sequencer_hold_counter.sv | 38 +++
 rtl/port_stimulus_sequencer.sv | 136 +++++++++++++
 tb/tb_port_stimulus_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/port_stimulus_sequencer_pkg.sv
// Shared definitions for the port stimulus sequencer: FSM state encodings
// and the number of {C,D} vectors driven per sequence.
package port_stimulus_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/port_stimulus_sequencer_hold_counter.sv
// Counts 0..HOLD_CYCLES-1 while enabled and wraps to zero; terminal flags the
// last hold cycle of the current vector.
module port_stimulus_sequencer_hold_counter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_r;

    // Terminal count decode
    always_comb begin
        terminal = (count_r == CNT_W'(HOLD_CYCLES - 1));
    end

    // Hold-cycle counter with synchronous clear and wrap on terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (terminal) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/port_stimulus_sequencer.sv
// Clocked stimulus sequencer: walks {C,D} through 00..11, holding each vector
// HOLD_CYCLES cycles, and logs the consumer's {A,B} response per vector.
module port_stimulus_sequencer
    import port_stimulus_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       C,
    output logic       D,
    input  logic       A_in,
    input  logic       B_in,
    output logic       busy,
    output logic       done,
    input  logic [1:0] log_rd_idx,
    output logic [1:0] log_rd_data
);

    seq_state_t state_r;
    seq_state_t state_s;
    logic [1:0] idx_r;
    logic [1:0] idx_s;
    logic [1:0] cd_r;
    logic [1:0] cd_s;
    logic       busy_r;
    logic       busy_s;
    logic       done_r;
    logic       done_s;
    logic       log_we_s;
    logic       term_s;
    logic       in_drive_s;
    logic [1:0] log_r [NUM_VECTORS];

    assign in_drive_s = (state_r == ST_DRIVE);

    port_stimulus_sequencer_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (!in_drive_s),
        .enable   (in_drive_s),
        .terminal (term_s)
    );

    // Next-state and next-output decode; outputs are registered one edge later
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cd_s     = 2'b00;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        log_we_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_DRIVE;
                    idx_s   = 2'd0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                busy_s = 1'b1;
                cd_s   = idx_r;
                if (term_s) begin
                    log_we_s = 1'b1;
                    if (idx_r == 2'(NUM_VECTORS - 1)) begin
                        // Last vector sampled: drop drive and pulse done
                        state_s = ST_DONE;
                        idx_s   = 2'd0;
                        cd_s    = 2'b00;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        idx_s = idx_r + 2'd1;
                        cd_s  = idx_r + 2'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 2'd0;
            end
        endcase
    end

    // State, vector index and registered output drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            cd_r    <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cd_r    <= cd_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Response log capture on the closing edge of each vector's hold window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                log_r[i] <= 2'b00;
            end
        end else if (log_we_s) begin
            log_r[idx_r] <= {A_in, B_in};
        end else begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                log_r[i] <= log_r[i];
            end
        end
    end

    assign C           = cd_r[1];
    assign D           = cd_r[0];
    assign busy        = busy_r;
    assign done        = done_r;
    assign log_rd_data = log_r[log_rd_idx];

endmodule

// File: tb/tb_port_stimulus_sequencer.sv
// Directed bench for port_stimulus_sequencer: one instance with HOLD_CYCLES=4
// and one with HOLD_CYCLES=1, each driving a modelled consumer.
module tb_port_stimulus_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_s = 1'b0;
    logic       sel = 1'b0;
    logic       float_mode = 1'b0;
    logic       z_bit;
    logic [1:0] rd_idx = 2'd0;

    logic       start4, c4, d4, a4, b4, busy4, done4;
    logic       start1, c1, d1, a1, b1, busy1, done1;
    logic [1:0] data4, data1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign start4 = start_s & ~sel;
    assign start1 = start_s & sel;
    assign a4 = float_mode ? z_bit : (c4 ^ d4);
    assign b4 = float_mode ? c4 : (c4 & d4);
    assign a1 = c1 ^ d1;
    assign b1 = c1 & d1;

    port_stimulus_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .C(c4), .D(d4),
        .A_in(a4), .B_in(b4), .busy(busy4), .done(done4),
        .log_rd_idx(rd_idx), .log_rd_data(data4)
    );

    port_stimulus_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .C(c1), .D(d1),
        .A_in(a1), .B_in(b1), .busy(busy1), .done(done1),
        .log_rd_idx(rd_idx), .log_rd_data(data1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one sequence on the selected instance and measure busy/done/CD timing.
    task automatic run_seq(input string tag, input int hold, input int restart_k, input bit restart_done);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_k   = -1;
        int cd_err   = 0;
        logic b, dn;
        logic [1:0] cd, exp_cd;
        start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 1; k <= 4 * hold + 6; k++) begin
            b  = sel ? busy1 : busy4;
            dn = sel ? done1 : done4;
            cd = sel ? {c1, d1} : {c4, d4};
            exp_cd = (k <= 4 * hold) ? 2'((k - 1) / hold) : 2'b00;
            if (cd !== exp_cd) cd_err++;
            if (b === 1'b1) busy_cnt++;
            if (dn === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == restart_k) start_s = 1'b1;
            else if (restart_done && dn === 1'b1) start_s = 1'b1;
            else start_s = 1'b0;
            @(negedge clk);
        end
        start_s = 1'b0;
        chk_eq({tag, "_busy_cycles"}, busy_cnt, 4 * hold);
        chk_eq({tag, "_done_cycle"}, done_k, 4 * hold + 1);
        chk_eq({tag, "_done_pulses"}, done_cnt, 1);
        chk_eq({tag, "_cd_errors"}, cd_err, 0);
    endtask

    task automatic chk_log(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] exp_v [4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk_eq($sformatf("%s_log%0d", tag, i), {30'd0, sel ? data1 : data4}, {30'd0, exp_v[i]});
        end
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        z_bit = 1'bz;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_outs4", {28'd0, c4, d4, busy4, done4}, 32'd0);
        chk_eq("rst_outs1", {28'd0, c1, d1, busy1, done1}, 32'd0);
        sel = 1'b0; chk_log("rst4", 2'b00, 2'b00, 2'b00, 2'b00);
        reset_n = 1'b1;
        @(negedge clk);

        // Baseline runs with the XOR/AND consumer
        sel = 1'b0;
        run_seq("h4", 4, 0, 1'b0);
        chk_log("h4", 2'b00, 2'b10, 2'b10, 2'b01);
        sel = 1'b1;
        run_seq("h1", 1, 0, 1'b0);
        chk_log("h1", 2'b00, 2'b10, 2'b10, 2'b01);

        // Starts during DRIVE and in the done cycle must be ignored
        sel = 1'b0;
        run_seq("restart", 4, 6, 1'b1);

        // Asynchronous reset in the middle of a run
        start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("abort_outs", {28'd0, c4, d4, busy4, done4}, 32'd0);
        chk_log("abort", 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        busy_seen = 0;
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy4 === 1'b1) busy_seen++;
            if (done4 === 1'b1) done_seen++;
        end
        chk_eq("abort_no_busy", busy_seen, 0);
        chk_eq("abort_no_done", done_seen, 0);

        // Floating A with B following C
        float_mode = 1'b1;
        run_seq("float", 4, 0, 1'b0);
        chk_log("float", {z_bit, 1'b0}, {z_bit, 1'b0}, {z_bit, 1'b1}, {z_bit, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
